// File: rtl/wb_test_slave_ram.sv
// rtl/wb_test_slave_ram.sv - Wishbone classic slave RAM with byte-lane writes and programmable wait states
module wb_test_slave_ram #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    wb_clk,
  input  logic                    wb_rst,
  input  logic [31:0]             wb_addr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_bwsel_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  input  logic                    wb_we_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  input  logic [3:0]              wait_states_i,
  output logic [CNT_WIDTH-1:0]    wr_count_o,
  output logic [CNT_WIDTH-1:0]    rd_count_o,
  output logic                    unmapped_o
);

  localparam int SEL_W = DATA_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                  state, next_state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [DATA_WIDTH-1:0]   rd_q;
  logic [SEL_W-1:0]        sel_q;
  logic                    we_q;
  logic                    mapped_q;
  logic [3:0]              wcnt;
  logic                    req;
  logic                    sample;
  logic                    enter_ack;
  logic                    addr_mapped;
  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic [SEL_W-1:0]        cur_sel;
  logic                    cur_we;
  logic                    cur_mapped;

  logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];

  assign req         = wb_cyc_i && wb_stb_i;
  assign addr_mapped = (wb_addr_i[31:ADDR_WIDTH] == '0);
  assign wb_ack_o    = (state == ACK);
  assign wb_dat_o    = rd_q;

  always_comb begin
    next_state = state;
    sample     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          sample     = 1'b1;
          next_state = (wait_states_i == 4'd0) ? ACK : WAIT;
        end
      end
      WAIT: begin
        if (!req)
          next_state = IDLE;
        else if (wcnt == 4'd1)
          next_state = ACK;
      end
      ACK:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
    if (wb_rst) begin
      next_state = IDLE;
      sample     = 1'b0;
    end
  end

  // A zero-wait access goes straight from IDLE to ACK, so it must use the live bus inputs.
  always_comb begin
    cur_addr   = addr_q;
    cur_dat    = dat_q;
    cur_sel    = sel_q;
    cur_we     = we_q;
    cur_mapped = mapped_q;
    if (state == IDLE) begin
      cur_addr   = wb_addr_i[ADDR_WIDTH-1:0];
      cur_dat    = wb_dat_i;
      cur_sel    = wb_bwsel_i;
      cur_we     = wb_we_i;
      cur_mapped = addr_mapped;
    end
    enter_ack = (next_state == ACK) && (state != ACK);
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state      <= IDLE;
      rd_q       <= '0;
      wr_count_o <= '0;
      rd_count_o <= '0;
      unmapped_o <= 1'b0;
      wcnt       <= 4'd0;
    end else begin
      state <= next_state;
      if (sample) begin
        addr_q   <= wb_addr_i[ADDR_WIDTH-1:0];
        dat_q    <= wb_dat_i;
        sel_q    <= wb_bwsel_i;
        we_q     <= wb_we_i;
        mapped_q <= addr_mapped;
        wcnt     <= wait_states_i;
        if (!addr_mapped)
          unmapped_o <= 1'b1;
      end else if (state == WAIT) begin
        wcnt <= wcnt - 4'd1;
      end
      if (enter_ack) begin
        rd_q <= (cur_mapped && !cur_we) ? mem[cur_addr] : '0;
        if (cur_mapped && cur_we)
          wr_count_o <= wr_count_o + CNT_ONE;
        if (cur_mapped && !cur_we)
          rd_count_o <= rd_count_o + CNT_ONE;
      end else begin
        rd_q <= '0;
      end
    end
  end

  always_ff @(posedge wb_clk) begin
    for (int i = 0; i < SEL_W; i++) begin
      if (enter_ack && cur_we && cur_mapped && cur_sel[i])
        mem[cur_addr][8*i +: 8] <= cur_dat[8*i +: 8];
    end
  end

endmodule

// File: tb/tb_wb_test_slave_ram.sv
// tb/tb_wb_test_slave_ram.sv - self-checking bench for wb_test_slave_ram against a behavioural RAM model
module tb_wb_test_slave_ram;

  logic        wb_clk = 1'b0;
  logic        wb_rst;
  logic [31:0] wb_addr_i;
  logic [31:0] wb_dat_i;
  logic [3:0]  wb_bwsel_i;
  logic        wb_cyc_i;
  logic        wb_stb_i;
  logic        wb_we_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic [3:0]  wait_states_i;
  logic [15:0] wr_count_o;
  logic [15:0] rd_count_o;
  logic        unmapped_o;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [1024];
  int          ref_wr = 0;
  int          ref_rd = 0;
  bit          ref_unm = 0;

  always #5 wb_clk = ~wb_clk;

  wb_test_slave_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .wb_addr_i(wb_addr_i), .wb_dat_i(wb_dat_i),
    .wb_bwsel_i(wb_bwsel_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wait_states_i(wait_states_i),
    .wr_count_o(wr_count_o), .rd_count_o(rd_count_o), .unmapped_o(unmapped_o)
  );

  // Reference: what a completed access does to memory, counters and the sticky flag.
  task automatic model(input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, output logic [31:0] exp_rd);
    exp_rd = 32'h0;
    if (addr[31:10] != 0) begin
      ref_unm = 1;
    end else if (we) begin
      for (int i = 0; i < 4; i++)
        if (sel[i]) ref_mem[addr[9:0]][8*i +: 8] = dat[8*i +: 8];
      ref_wr = (ref_wr + 1) % 65536;
    end else begin
      exp_rd = ref_mem[addr[9:0]];
      ref_rd = (ref_rd + 1) % 65536;
    end
  endtask

  task automatic bus_idle();
    @(negedge wb_clk);
    wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0;
  endtask

  // Runs one access; lat = edges after the sampling edge until ack is seen (-1 on timeout).
  task automatic access(input logic [31:0] addr, input logic [31:0] dat, input logic [3:0] sel,
                        input logic we, input logic [3:0] ws, input logic [3:0] ws_mid,
                        output int lat, output logic [31:0] rdata, output bit clean);
    @(negedge wb_clk);
    wb_addr_i = addr; wb_dat_i = dat; wb_bwsel_i = sel; wb_we_i = we;
    wb_cyc_i = 1; wb_stb_i = 1; wait_states_i = ws;
    lat = -1; rdata = 32'h0; clean = 0;
    @(posedge wb_clk); #1;
    wait_states_i = ws_mid;
    for (int k = 0; k < 40; k++) begin
      if (wb_ack_o) begin
        lat = k; rdata = wb_dat_o;
        break;
      end
      @(posedge wb_clk); #1;
    end
    if (lat >= 0) begin
      @(posedge wb_clk); #1;
      clean = (wb_ack_o === 1'b0) && (wb_dat_o === 32'h0);
    end
  endtask

  task automatic test_reset();
    wb_rst = 1; wb_cyc_i = 0; wb_stb_i = 0; wb_we_i = 0; wb_addr_i = 0; wb_dat_i = 0;
    wb_bwsel_i = 0; wait_states_i = 0;
    repeat (3) @(posedge wb_clk);
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b expected 0", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
    checks++; if (wr_count_o !== 16'h0 || rd_count_o !== 16'h0) begin errors++; $display("FAIL reset_counts: got wr %0d rd %0d expected 0 0", wr_count_o, rd_count_o); end
    checks++; if (unmapped_o !== 1'b0) begin errors++; $display("FAIL reset_unmapped: got %b expected 0", unmapped_o); end
    @(negedge wb_clk); wb_rst = 0;
  endtask

  task automatic test_basic();
    int lat; logic [31:0] rd, exp; bit clean;
    access(32'h4, 32'hCAFEBABE, 4'hF, 1, 0, 0, lat, rd, clean); model(32'h4, 32'hCAFEBABE, 4'hF, 1, exp);
    checks++; if (lat != 0 || !clean) begin errors++; $display("FAIL basic_wr_ack: got lat %0d clean %0d expected 0 1", lat, clean); end
    access(32'h4, 32'h0, 4'hF, 0, 0, 0, lat, rd, clean); model(32'h4, 32'h0, 4'hF, 0, exp);
    bus_idle();
    checks++; if (lat != 0 || !clean) begin errors++; $display("FAIL basic_rd_ack: got lat %0d clean %0d expected 0 1", lat, clean); end
    checks++; if (rd !== 32'hCAFEBABE) begin errors++; $display("FAIL basic_rd_data: got %h expected cafebabe", rd); end
    checks++; if (wr_count_o !== 16'd1 || rd_count_o !== 16'd1) begin errors++; $display("FAIL basic_counts: got wr %0d rd %0d expected 1 1", wr_count_o, rd_count_o); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd, exp; bit clean;
    access(32'h8, 32'h11223344, 4'hF, 1, 0, 0, lat, rd, clean); model(32'h8, 32'h11223344, 4'hF, 1, exp);
    access(32'h8, 32'hAA000000, 4'h8, 1, 0, 0, lat, rd, clean); model(32'h8, 32'hAA000000, 4'h8, 1, exp);
    access(32'h8, 32'h000000BB, 4'h1, 1, 0, 0, lat, rd, clean); model(32'h8, 32'h000000BB, 4'h1, 1, exp);
    access(32'h8, 32'hFFFFFFFF, 4'h0, 1, 1, 1, lat, rd, clean); model(32'h8, 32'hFFFFFFFF, 4'h0, 1, exp);
    checks++; if (lat != 1 || !clean) begin errors++; $display("FAIL lanes_sel0_ack: got lat %0d clean %0d expected 1 1", lat, clean); end
    access(32'h8, 32'h0, 4'hF, 0, 0, 0, lat, rd, clean); model(32'h8, 32'h0, 4'hF, 0, exp);
    bus_idle();
    checks++; if (rd !== 32'hAA2233BB) begin errors++; $display("FAIL lanes_rd_data: got %h expected aa2233bb", rd); end
    checks++; if (wr_count_o !== 16'(ref_wr)) begin errors++; $display("FAIL lanes_wr_count: got %0d expected %0d", wr_count_o, ref_wr); end
  endtask

  task automatic test_wait_states();
    int lat; logic [31:0] rd, exp; bit clean;
    access(32'h30, 32'h0BADF00D, 4'hF, 1, 0, 0, lat, rd, clean); model(32'h30, 32'h0BADF00D, 4'hF, 1, exp);
    access(32'h30, 32'h0, 4'hF, 0, 3, 3, lat, rd, clean); model(32'h30, 32'h0, 4'hF, 0, exp);
    checks++; if (lat != 3 || !clean) begin errors++; $display("FAIL wait3_ack: got lat %0d clean %0d expected 3 1", lat, clean); end
    checks++; if (rd !== exp) begin errors++; $display("FAIL wait3_data: got %h expected %h", rd, exp); end
    access(32'h30, 32'h0, 4'hF, 0, 3, 0, lat, rd, clean); model(32'h30, 32'h0, 4'hF, 0, exp);
    checks++; if (lat != 3 || !clean) begin errors++; $display("FAIL wait_change_ack: got lat %0d clean %0d expected 3 1", lat, clean); end
    access(32'h30, 32'h0, 4'hF, 0, 15, 15, lat, rd, clean); model(32'h30, 32'h0, 4'hF, 0, exp);
    bus_idle();
    checks++; if (lat != 15 || rd !== exp) begin errors++; $display("FAIL wait15: got lat %0d data %h expected 15 %h", lat, rd, exp); end
  endtask

  task automatic test_abort();
    int lat; logic [31:0] rd, exp; bit clean, seen;
    access(32'h10, 32'h12345678, 4'hF, 1, 0, 0, lat, rd, clean); model(32'h10, 32'h12345678, 4'hF, 1, exp);
    bus_idle();
    @(negedge wb_clk);
    wb_addr_i = 32'h10; wb_dat_i = 32'h55; wb_bwsel_i = 4'hF; wb_we_i = 1;
    wb_cyc_i = 1; wb_stb_i = 1; wait_states_i = 5;
    seen = 0;
    repeat (3) begin @(posedge wb_clk); #1; seen |= wb_ack_o; end
    @(negedge wb_clk); wb_cyc_i = 0; wb_stb_i = 0;
    repeat (10) begin @(posedge wb_clk); #1; seen |= wb_ack_o; end
    checks++; if (seen) begin errors++; $display("FAIL abort_no_ack: got ack 1 expected 0"); end
    checks++; if (wr_count_o !== 16'(ref_wr)) begin errors++; $display("FAIL abort_wr_count: got %0d expected %0d", wr_count_o, ref_wr); end
    access(32'h10, 32'h0, 4'hF, 0, 0, 0, lat, rd, clean); model(32'h10, 32'h0, 4'hF, 0, exp);
    bus_idle();
    checks++; if (rd !== 32'h12345678) begin errors++; $display("FAIL abort_word: got %h expected 12345678", rd); end
  endtask

  task automatic test_unmapped();
    int lat; logic [31:0] rd, exp; bit clean;
    access(32'h0, 32'h600DD00D, 4'hF, 1, 0, 0, lat, rd, clean); model(32'h0, 32'h600DD00D, 4'hF, 1, exp);
    access(32'h00010000, 32'hDEADBEEF, 4'hF, 1, 2, 2, lat, rd, clean); model(32'h00010000, 32'hDEADBEEF, 4'hF, 1, exp);
    checks++; if (lat != 2 || !clean) begin errors++; $display("FAIL unmapped_wr_ack: got lat %0d clean %0d expected 2 1", lat, clean); end
    checks++; if (unmapped_o !== 1'b1) begin errors++; $display("FAIL unmapped_flag: got %b expected 1", unmapped_o); end
    access(32'h00010000, 32'h0, 4'hF, 0, 2, 2, lat, rd, clean); model(32'h00010000, 32'h0, 4'hF, 0, exp);
    checks++; if (lat != 2 || rd !== 32'h0) begin errors++; $display("FAIL unmapped_rd: got lat %0d data %h expected 2 0", lat, rd); end
    access(32'h0, 32'h0, 4'hF, 0, 0, 0, lat, rd, clean); model(32'h0, 32'h0, 4'hF, 0, exp);
    bus_idle();
    checks++; if (rd !== 32'h600DD00D) begin errors++; $display("FAIL unmapped_word0: got %h expected 600dd00d", rd); end
    checks++; if (wr_count_o !== 16'(ref_wr) || rd_count_o !== 16'(ref_rd)) begin errors++; $display("FAIL unmapped_counts: got wr %0d rd %0d expected %0d %0d", wr_count_o, rd_count_o, ref_wr, ref_rd); end
  endtask

  task automatic test_reset_mid_wait();
    int lat; logic [31:0] rd, exp, old; bit clean, seen;
    old = $urandom;
    access(32'h20, old, 4'hF, 1, 0, 0, lat, rd, clean); model(32'h20, old, 4'hF, 1, exp);
    @(negedge wb_clk);
    wb_addr_i = 32'h20; wb_dat_i = ~old; wb_bwsel_i = 4'hF; wb_we_i = 1;
    wb_cyc_i = 1; wb_stb_i = 1; wait_states_i = 7;
    seen = 0;
    repeat (3) begin @(posedge wb_clk); #1; seen |= wb_ack_o; end
    @(negedge wb_clk); wb_rst = 1; wb_cyc_i = 0; wb_stb_i = 0;
    @(posedge wb_clk); #1; seen |= wb_ack_o;
    checks++; if (wb_dat_o !== 32'h0 || wr_count_o !== 16'h0 || rd_count_o !== 16'h0 || unmapped_o !== 1'b0) begin
      errors++; $display("FAIL rst_wait_outputs: got dat %h wr %0d rd %0d unm %b expected all 0", wb_dat_o, wr_count_o, rd_count_o, unmapped_o); end
    @(negedge wb_clk); wb_rst = 0;
    ref_wr = 0; ref_rd = 0; ref_unm = 0;
    repeat (8) begin @(posedge wb_clk); #1; seen |= wb_ack_o; end
    checks++; if (seen) begin errors++; $display("FAIL rst_wait_no_ack: got ack 1 expected 0"); end
    access(32'h20, 32'h0, 4'hF, 0, 0, 0, lat, rd, clean); model(32'h20, 32'h0, 4'hF, 0, exp);
    bus_idle();
    checks++; if (lat != 0 || rd !== old) begin errors++; $display("FAIL rst_wait_next: got lat %0d data %h expected 0 %h", lat, rd, old); end
    checks++; if (rd_count_o !== 16'd1 || wr_count_o !== 16'd0) begin errors++; $display("FAIL rst_wait_counts: got wr %0d rd %0d expected 0 1", wr_count_o, rd_count_o); end
  endtask

  // Back-to-back random traffic over a small pre-initialised address set.
  task automatic test_back_to_back();
    int lat; logic [31:0] rd, exp, addr, dat; bit clean; logic [3:0] sel, ws; logic we;
    logic [31:0] addrs [8];
    for (int i = 0; i < 8; i++) begin
      addrs[i] = {22'h0, 10'($urandom_range(64, 1023))};
      dat = $urandom;
      access(addrs[i], dat, 4'hF, 1, 0, 0, lat, rd, clean); model(addrs[i], dat, 4'hF, 1, exp);
    end
    for (int n = 0; n < 60; n++) begin
      addr = addrs[$urandom_range(0, 7)];
      if ($urandom_range(0, 7) == 0) addr[31:10] = 22'($urandom_range(1, 32'h3FFFFF));
      dat = $urandom; sel = 4'($urandom); we = 1'($urandom); ws = 4'($urandom_range(0, 4));
      access(addr, dat, sel, we, ws, 4'($urandom), lat, rd, clean); model(addr, dat, sel, we, exp);
      checks++; if (lat != int'(ws) || !clean) begin errors++; $display("FAIL b2b_ack[%0d]: got lat %0d clean %0d expected %0d 1", n, lat, clean, ws); end
      if (!we) begin
        checks++; if (rd !== exp) begin errors++; $display("FAIL b2b_data[%0d]: addr %h got %h expected %h", n, addr, rd, exp); end
      end
    end
    bus_idle();
    checks++; if (wr_count_o !== 16'(ref_wr) || rd_count_o !== 16'(ref_rd) || unmapped_o !== 1'(ref_unm)) begin
      errors++; $display("FAIL b2b_state: got wr %0d rd %0d unm %b expected %0d %0d %0d", wr_count_o, rd_count_o, unmapped_o, ref_wr, ref_rd, ref_unm); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_byte_lanes();
    test_wait_states();
    test_abort();
    test_unmapped();
    test_reset_mid_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
